float_adder: RTL and testbench

FLOAT_ADDER -- requirements
Module: float_adder

---
 rtl/float_adder.sv | 207 ++++++++++++++++++++
 tb/tb_float_adder.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/float_adder.sv
// Multi-cycle IEEE-754 single-precision adder.
// One operation at a time: IDLE -> ALIGN -> ADD -> NORM -> ROUND -> DONE.
// Denormal operands are flushed to zero, results never go denormal, and
// rounding is round-to-nearest-even using guard/round/sticky bits.
module float_adder (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        ack,
  input  logic [31:0] fl_in_1,
  input  logic [31:0] fl_in_2,
  output logic [31:0] res
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    ADD   = 3'd2,
    NORM  = 3'd3,
    ROUND = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t state, state_nxt;
  logic   cap_en, res_en;

  // Working word layout: {hidden, frac[22:0], guard, round, sticky}
  logic [31:0]        a_p0, b_p0;
  logic               nan_1, nan_2, inf_1, inf_2;
  logic [30:0]        mag_1, mag_2, big_mag, small_mag;
  logic               big_s, small_s;
  logic [7:0]         exp_diff;
  logic [26:0]        mb_raw, mb_al;
  logic               spec_n;
  logic [31:0]        spec_val_n;

  logic               spec_p1, sign_p1, sub_p1;
  logic [31:0]        spec_val_p1;
  logic [7:0]         exp_p1;
  logic [26:0]        ma_p1, mb_p1;

  logic               spec_p2, sign_p2;
  logic [31:0]        spec_val_p2;
  logic signed [9:0]  exp_p2;
  logic [27:0]        sum_p2;

  logic [4:0]         lz;
  logic [26:0]        mant_n;
  logic signed [9:0]  exp_n;
  logic               zero_n, sign_n;

  logic               spec_p3, sign_p3, zero_p3;
  logic [31:0]        spec_val_p3;
  logic signed [9:0]  exp_p3;
  logic [26:0]        mant_p3;

  logic [24:0]        rnd;
  logic signed [9:0]  exp_r;
  logic [31:0]        res_n;

  // Leading-zero count of a 27-bit word (27 when the word is zero).
  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    logic       found;
    n     = 5'd27;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 5'(26 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  // Round-to-nearest, ties-to-even; bit 24 of the result flags mantissa overflow.
  function automatic logic [24:0] round_rne(input logic [26:0] m);
    logic up;
    up = m[2] & (m[1] | m[0] | m[3]);
    return {1'b0, m[26:3]} + 25'(up);
  endfunction

  // Pack a normalised result, saturating an out-of-range exponent to infinity.
  function automatic logic [31:0] sat_pack(input logic s, input logic signed [9:0] e,
                                           input logic [22:0] f);
    if (e >= 10'sd255) return {s, 8'hFF, 23'd0};
    return {s, e[7:0], f};
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic: fixed walk through the datapath steps.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ALIGN;
      ALIGN:   state_nxt = ADD;
      ADD:     state_nxt = NORM;
      NORM:    state_nxt = ROUND;
      ROUND:   state_nxt = DONE;
      DONE:    if (ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control strobes: operand capture and result load.
  always_comb begin
    cap_en = (state == IDLE) && start;
    res_en = (state == ROUND);
  end

  // Operand capture.
  always_ff @(posedge clk) begin
    if (cap_en) begin
      a_p0 <= fl_in_1;
      b_p0 <= fl_in_2;
    end
  end

  // ---- ALIGN: specials, magnitude ordering, right shift of the smaller operand
  always_comb begin
    nan_1 = (a_p0[30:23] == 8'hFF) && (a_p0[22:0] != 23'd0);
    nan_2 = (b_p0[30:23] == 8'hFF) && (b_p0[22:0] != 23'd0);
    inf_1 = (a_p0[30:23] == 8'hFF) && (a_p0[22:0] == 23'd0);
    inf_2 = (b_p0[30:23] == 8'hFF) && (b_p0[22:0] == 23'd0);
    spec_n = nan_1 | nan_2 | inf_1 | inf_2;
    if (nan_1 || nan_2 || (inf_1 && inf_2 && (a_p0[31] != b_p0[31]))) spec_val_n = 32'h7FC00000;
    else if (inf_1)                                                    spec_val_n = a_p0;
    else                                                               spec_val_n = b_p0;
    // Denormals collapse to a zero magnitude here.
    mag_1 = (a_p0[30:23] == 8'd0) ? 31'd0 : a_p0[30:0];
    mag_2 = (b_p0[30:23] == 8'd0) ? 31'd0 : b_p0[30:0];
    if (mag_2 > mag_1) begin
      big_mag = mag_2; big_s = b_p0[31]; small_mag = mag_1; small_s = a_p0[31];
    end else begin
      big_mag = mag_1; big_s = a_p0[31]; small_mag = mag_2; small_s = b_p0[31];
    end
    exp_diff = big_mag[30:23] - small_mag[30:23];
    mb_raw   = (small_mag[30:23] == 8'd0) ? 27'd0 : {1'b1, small_mag[22:0], 3'b000};
    if (exp_diff >= 8'd27) mb_al = {26'd0, |mb_raw};
    else mb_al = (mb_raw >> exp_diff) | {26'd0, |(mb_raw & ((27'd1 << exp_diff) - 27'd1))};
  end

  // ALIGN results.
  always_ff @(posedge clk) begin
    spec_p1     <= spec_n;
    spec_val_p1 <= spec_val_n;
    sign_p1     <= big_s;
    sub_p1      <= big_s ^ small_s;
    exp_p1      <= big_mag[30:23];
    ma_p1       <= (big_mag[30:23] == 8'd0) ? 27'd0 : {1'b1, big_mag[22:0], 3'b000};
    mb_p1       <= mb_al;
  end

  // ---- ADD: magnitude add or subtract (A is never smaller than B)
  always_ff @(posedge clk) begin
    spec_p2     <= spec_p1;
    spec_val_p2 <= spec_val_p1;
    sign_p2     <= sign_p1;
    exp_p2      <= $signed({2'b00, exp_p1});
    sum_p2      <= sub_p1 ? ({1'b0, ma_p1} - {1'b0, mb_p1}) : ({1'b0, ma_p1} + {1'b0, mb_p1});
  end

  // ---- NORM: carry right shift or leading-zero left shift, underflow flush
  always_comb begin
    lz = lzc27(sum_p2[26:0]);
    if (sum_p2[27]) begin
      mant_n = {sum_p2[27:2], sum_p2[1] | sum_p2[0]};
      exp_n  = exp_p2 + 10'sd1;
    end else begin
      mant_n = sum_p2[26:0] << lz;
      exp_n  = exp_p2 - $signed({5'd0, lz});
    end
    zero_n = (sum_p2 == 28'd0) || (exp_n <= 10'sd0);
    sign_n = (sum_p2 == 28'd0) ? 1'b0 : sign_p2;
  end

  // NORM results.
  always_ff @(posedge clk) begin
    spec_p3     <= spec_p2;
    spec_val_p3 <= spec_val_p2;
    sign_p3     <= sign_n;
    zero_p3     <= zero_n;
    exp_p3      <= exp_n;
    mant_p3     <= mant_n;
  end

  // ---- ROUND: nearest-even rounding, overflow to infinity, final packing
  always_comb begin
    rnd   = round_rne(mant_p3);
    exp_r = exp_p3 + $signed({9'd0, rnd[24]});
    if (spec_p3)      res_n = spec_val_p3;
    else if (zero_p3) res_n = {sign_p3, 31'd0};
    else              res_n = sat_pack(sign_p3, exp_r, rnd[24] ? rnd[23:1] : rnd[22:0]);
  end

  // Result register: loaded on DONE entry, held otherwise.
  always_ff @(posedge clk) begin
    if (!rst)        res <= 32'h00000000;
    else if (res_en) res <= res_n;
  end

endmodule

// File: tb/tb_float_adder.sv
// Bench for float_adder: randomized and directed operand pairs, an exact
// big-integer reference model, and a scoreboard monitor that compares res on
// every cycle (expected result while in DONE, held value otherwise).
module tb_float_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        ack = 1'b0;
  logic [31:0] fl_in_1 = 32'd0;
  logic [31:0] fl_in_2 = 32'd0;
  logic [31:0] res;

  float_adder dut (
    .clk(clk), .rst(rst), .start(start), .ack(ack),
    .fl_in_1(fl_in_1), .fl_in_2(fl_in_2), .res(res)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] val;
    int          first;
    int          last;
  } item_t;

  item_t       exp_q[$];
  int          edges = 0;
  logic [31:0] hold_val = 32'd0;
  int          n_chk = 0;
  int          n_pass = 0;

  logic [31:0] sp_tab [10] = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000,
                               32'h7FC00000, 32'h7F7FFFFF, 32'h00000001, 32'h00800000,
                               32'h3F800000, 32'hBF800000};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %h, expected %h (edge %0d)", name, act, want, edges);
  endtask

  // Exact reference: operands become integers in units of 2^-149, summed exactly,
  // then rounded to 24 significant bits with ties to even.
  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    logic [279:0] ma, mb, mag, m, rem, half;
    logic         s, up;
    int           ea, eb, p, e, sh;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0)) return 32'h7FC00000;
    if (ea == 255 && eb == 255) return (a[31] != b[31]) ? 32'h7FC00000 : a;
    if (ea == 255) return a;
    if (eb == 255) return b;
    ma = (ea == 0) ? '0 : (280'({1'b1, a[22:0]}) << (ea - 1));
    mb = (eb == 0) ? '0 : (280'({1'b1, b[22:0]}) << (eb - 1));
    if (a[31] == b[31]) begin mag = ma + mb; s = a[31]; end
    else if (ma >= mb)  begin mag = ma - mb; s = a[31]; end
    else                begin mag = mb - ma; s = b[31]; end
    if (mag == 0) return 32'h00000000;
    p = 0;
    for (int i = 0; i < 280; i++) if (mag[i]) p = i;
    e = p - 22;
    if (e <= 0) return {s, 31'd0};
    sh = p - 23;
    m  = mag >> sh;
    up = 1'b0;
    if (sh > 0) begin
      rem  = mag & ((280'd1 << sh) - 280'd1);
      half = 280'd1 << (sh - 1);
      up   = (rem > half) || ((rem == half) && m[0]);
    end
    m = m + 280'(up);
    if (m[24]) begin m = m >> 1; e++; end
    if (e >= 255) return {s, 8'hFF, 23'd0};
    return {s, 8'(e), m[22:0]};
  endfunction

  function automatic logic [31:0] rnd_op(input logic [31:0] other, input int mode);
    case (mode)
      0:       return $urandom;
      1:       return {1'($urandom), 8'(32'(other[30:23]) + $urandom_range(0, 4) - 2), 23'($urandom)};
      2:       return sp_tab[$urandom_range(0, 9)];
      default: return {1'($urandom), 8'($urandom_range(1, 6)), 23'($urandom)};
    endcase
  endfunction

  // One full transaction starting at a negedge: start, wait out the operation,
  // linger h cycles in DONE, then ack (optionally with start also high).
  task automatic txn(input logic [31:0] x, input logic [31:0] y, input int h, input logic sa);
    item_t it;
    it.val   = ref_add(x, y);
    it.first = edges + 5;
    it.last  = edges + 5 + h;
    exp_q.push_back(it);
    fl_in_1 = x;
    fl_in_2 = y;
    start   = 1'b1;
    @(negedge clk);
    fl_in_1 = $urandom;
    fl_in_2 = $urandom;
    for (int i = 0; i < 4 + h; i++) begin
      start = 1'($urandom);
      @(negedge clk);
    end
    ack   = 1'b1;
    start = sa;
    @(negedge clk);
    ack   = 1'b0;
    start = 1'b0;
  endtask

  always @(posedge clk) edges <= edges + 1;

  // Monitor: DONE window of the head item checks the new result, otherwise res must hold.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0 && edges >= exp_q[0].first) begin
      check("done_res", res, exp_q[0].val);
      if (edges >= exp_q[0].last) begin
        hold_val = exp_q[0].val;
        void'(exp_q.pop_front());
      end
    end else begin
      check("held_res", res, hold_val);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] x, y;
    int          md;
    rst = 1'b0;
    hold_val = 32'd0;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    txn(32'h3F000000, 32'h3F800000, 3, 1'b0);
    txn(32'h3F800000, 32'hBF800000, 1, 1'b1);
    txn(32'h40400000, 32'hBF800000, 0, 1'b0);
    txn(32'h3F800000, 32'h33800000, 2, 1'b0);
    txn(32'h3F800000, 32'h33800001, 0, 1'b1);
    txn(32'h7F7FFFFF, 32'h7F7FFFFF, 1, 1'b0);
    txn(32'h7F800000, 32'hFF800000, 0, 1'b0);
    txn(32'h00000000, 32'h40490FDB, 0, 1'b0);
    txn(32'hC1200000, 32'h80000000, 0, 1'b0);
    txn(32'h00000001, 32'h3F800000, 0, 1'b0);
    txn(32'h00400000, 32'h00000000, 0, 1'b0);
    txn(32'hFF800000, 32'h3F800000, 0, 1'b0);
    txn(32'h7FC00001, 32'h3F800000, 0, 1'b0);
    txn(32'h00800000, 32'h80800001, 0, 1'b0);
    txn(32'h3F800001, 32'hBF800000, 0, 1'b0);

    // Reset while in ADD, then an immediate new start.
    fl_in_1 = 32'h40000000;
    fl_in_2 = 32'h40000000;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst      = 1'b0;
    hold_val = 32'd0;
    @(negedge clk);
    rst = 1'b1;
    txn(32'h40A00000, 32'hC0400000, 0, 1'b0);

    // Long DONE dwell with random start pulses.
    txn(32'h41200000, 32'h3DCCCCCD, 10, 1'b1);

    for (int k = 0; k < 250; k++) begin
      md = int'($urandom_range(0, 3));
      x  = rnd_op(32'd0, (md == 1) ? 0 : md);
      y  = rnd_op(x, int'($urandom_range(0, 3)));
      txn(x, y, int'($urandom_range(0, 2)), 1'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    check("queue_drain", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
